// File: rtl/alu_issue_if.sv
// alu_issue_if: fetch, ALU and redirect signals between the issue stage and its neighbours.
interface alu_issue_if;
    logic        Inst_valid_in;
    logic        Inst_ready_out;
    logic [31:0] Inst_in;
    logic [31:0] Pc_in;
    logic [31:0] Rs_data_in;
    logic [31:0] Rt_data_in;
    logic [5:0]  Func_out;
    logic [31:0] A_out;
    logic [31:0] B_out;
    logic [31:0] Pc_out;
    logic        Ex_valid_out;
    logic        Ex_ready_in;
    logic        Branch_in;
    logic        Jump_in;
    logic [31:0] O_in;
    logic        Redirect_valid_out;
    logic        Redirect_ready_in;
    logic [31:0] Redirect_pc_out;
    logic        Illegal_out;

    modport slave (
        input  Inst_valid_in, Inst_in, Pc_in, Rs_data_in, Rt_data_in,
        input  Ex_ready_in, Branch_in, Jump_in, O_in, Redirect_ready_in,
        output Inst_ready_out, Func_out, A_out, B_out, Pc_out, Ex_valid_out,
        output Redirect_valid_out, Redirect_pc_out, Illegal_out
    );

    modport master (
        output Inst_valid_in, Inst_in, Pc_in, Rs_data_in, Rt_data_in,
        output Ex_ready_in, Branch_in, Jump_in, O_in, Redirect_ready_in,
        input  Inst_ready_out, Func_out, A_out, B_out, Pc_out, Ex_valid_out,
        input  Redirect_valid_out, Redirect_pc_out, Illegal_out
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: MIPS decode/issue into ALU Func/A/B with branch/jump PC redirect.
// Define ALU_ISSUE_DELAY_SLOT_EN to issue one delay-slot instruction after a taken redirect.
module alu_issue (
    input logic       clock,
    input logic       reset,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {RUN, SLOT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [5:0]  func_q, func_d;
    logic [31:0] a_q, a_d, b_q, b_d, pc_q, pc_d, tgt_q, tgt_d, rpc_q, rpc_d;
    logic        ev_q, ev_d, ill_q, ill_d;
    logic [5:0]  op, fn, dfunc;
    logic [31:0] imm_s, imm_z, pc4, da, db, dtgt;
    logic        legal, is_ctl, accept, retire, taken, squash;

    always_comb begin
        op     = bus.Inst_in[31:26];
        fn     = bus.Inst_in[5:0];
        imm_s  = {{16{bus.Inst_in[15]}}, bus.Inst_in[15:0]};
        imm_z  = {16'h0, bus.Inst_in[15:0]};
        pc4    = bus.Pc_in + 32'd4;
        dfunc  = 6'h00;
        da     = bus.Rs_data_in;
        db     = bus.Rt_data_in;
        legal  = 1'b1;
        is_ctl = 1'b0;
        dtgt   = pc4 + {imm_s[29:0], 2'b00};
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: dfunc = 6'h20;
                6'h22, 6'h23: dfunc = 6'h22;
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: dfunc = fn;
                6'h08, 6'h09: dfunc = 6'h3B;
                default: legal = 1'b0;
            endcase
            6'h01: begin
                dfunc  = {5'b11100, bus.Inst_in[16]};
                legal  = bus.Inst_in[20:17] == 4'h0;
                is_ctl = 1'b1;
            end
            6'h02, 6'h03: begin
                dfunc  = 6'h3A;
                is_ctl = 1'b1;
                dtgt   = {pc4[31:28], bus.Inst_in[25:0], 2'b00};
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dfunc  = {4'b1111, op[1:0]};
                is_ctl = 1'b1;
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                dfunc = 6'h20;
                db    = imm_s;
            end
            6'h0A, 6'h0B: begin
                dfunc = {5'b10101, op[0]};
                db    = imm_s;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dfunc = {4'b1001, op[1:0]};
                db    = imm_z;
            end
            6'h0F: begin
                dfunc = 6'h25;
                da    = 32'h0;
                db    = {bus.Inst_in[15:0], 16'h0};
            end
            default: legal = 1'b0;
        endcase
    end

    assign bus.Inst_ready_out = !reset && state_q != HOLD && (!ev_q || bus.Ex_ready_in);
    assign accept = bus.Inst_valid_in && bus.Inst_ready_out;
    assign retire = ev_q && bus.Ex_ready_in;
    assign taken  = state_q == RUN && retire && (bus.Branch_in || bus.Jump_in);
`ifdef ALU_ISSUE_DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    assign squash = taken;
`endif

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ev_d    = ev_q && !retire;
        ill_d   = accept && !legal && !squash;
        rpc_d   = taken ? (func_q == 6'h3B ? bus.O_in : tgt_q) : rpc_q;
        if (accept && legal && !squash) begin
            func_d = dfunc;
            a_d    = da;
            b_d    = db;
            pc_d   = bus.Pc_in;
            tgt_d  = is_ctl ? dtgt : tgt_q;
            ev_d   = 1'b1;
        end
        case (state_q)
`ifdef ALU_ISSUE_DELAY_SLOT_EN
            RUN:  if (taken) state_d = accept ? HOLD : SLOT;
`else
            RUN:  if (taken) state_d = HOLD;
`endif
            SLOT: if (accept) state_d = HOLD;
            HOLD: if (bus.Redirect_ready_in) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            func_q  <= 6'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            pc_q    <= 32'h0;
            tgt_q   <= 32'h0;
            rpc_q   <= 32'h0;
            ev_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            rpc_q   <= rpc_d;
            ev_q    <= ev_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.Func_out           = func_q;
    assign bus.A_out              = a_q;
    assign bus.B_out              = b_q;
    assign bus.Pc_out             = pc_q;
    assign bus.Ex_valid_out       = ev_q;
    assign bus.Illegal_out        = ill_q;
    assign bus.Redirect_valid_out = state_q == HOLD;
    assign bus.Redirect_pc_out    = rpc_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed test-plan cases plus randomized traffic against a transaction-level model.
module tb_alu_issue;
`ifdef ALU_ISSUE_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_issue_if bus();
    alu_issue dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    bit          m_valid, m_pend, m_slot, m_ill;
    logic [5:0]  m_func;
    logic [31:0] m_a, m_b, m_pc, m_tgt, m_rpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0; m_pend = 0; m_slot = 0; m_ill = 0;
        m_func = 0; m_a = 0; m_b = 0; m_pc = 0; m_tgt = 0; m_rpc = 0;
    endfunction

    // Instruction semantics by mnemonic: legality, ALU code, operands, control target.
    function automatic void ref_dec(input logic [31:0] inst, pc, rs, rt,
                                    output bit ok, output logic [5:0] f,
                                    output logic [31:0] a, b, output bit has_t,
                                    output logic [31:0] t);
        logic [5:0]  op = inst[31:26];
        logic [5:0]  fn = inst[5:0];
        logic [31:0] se = {{16{inst[15]}}, inst[15:0]};
        logic [31:0] ze = {16'h0, inst[15:0]};
        ok = 1; f = 0; a = rs; b = rt; has_t = 0; t = 0;
        if (op == 0) begin
            if (fn == 6'h20 || fn == 6'h21) f = 6'h20;
            else if (fn == 6'h22 || fn == 6'h23) f = 6'h22;
            else if ((fn >= 6'h24 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B) f = fn;
            else if (fn == 6'h08 || fn == 6'h09) f = 6'h3B;
            else ok = 0;
        end else if (op == 1) begin
            if (inst[20:16] < 2) begin
                f = 6'h38 + 6'(inst[20:16]); has_t = 1; t = pc + 4 + se * 4;
            end else ok = 0;
        end else if (op == 2 || op == 3) begin
            logic [31:0] p4 = pc + 4;
            f = 6'h3A; has_t = 1; t = {p4[31:28], inst[25:0], 2'b00};
        end else if (op >= 4 && op <= 7) begin
            f = 6'h3C + (op - 6'h4); has_t = 1; t = pc + 4 + se * 4;
        end else if (op == 8 || op == 9 || op == 6'h23 || op == 6'h2B) begin
            f = 6'h20; b = se;
        end else if (op == 6'h0A) begin
            f = 6'h2A; b = se;
        end else if (op == 6'h0B) begin
            f = 6'h2B; b = se;
        end else if (op >= 6'h0C && op <= 6'h0E) begin
            f = 6'h24 + (op - 6'h0C); b = ze;
        end else if (op == 6'h0F) begin
            f = 6'h25; a = 0; b = {inst[15:0], 16'h0};
        end else ok = 0;
    endfunction

    function automatic void model_step(input bit rdy);
        bit ok, has_t, acc, ret, tk, drop;
        logic [5:0] f;
        logic [31:0] a, b, t, target;
        ref_dec(bus.Inst_in, bus.Pc_in, bus.Rs_data_in, bus.Rt_data_in, ok, f, a, b, has_t, t);
        acc    = bus.Inst_valid_in && rdy;
        ret    = m_valid && bus.Ex_ready_in;
        tk     = ret && (bus.Branch_in || bus.Jump_in) && !m_pend && !m_slot;
        drop   = tk && !DS;
        target = (m_func == 6'h3B) ? bus.O_in : m_tgt;
        m_ill  = acc && !ok && !drop;
        if (tk) begin
            m_rpc = target;
            if (DS && !acc) m_slot = 1; else m_pend = 1;
        end else if (m_slot && acc) begin
            m_slot = 0; m_pend = 1;
        end else if (m_pend && bus.Redirect_ready_in) m_pend = 0;
        if (acc && ok && !drop) begin
            m_valid = 1; m_func = f; m_a = a; m_b = b; m_pc = bus.Pc_in;
            if (has_t) m_tgt = t;
        end else if (ret) m_valid = 0;
    endfunction

    task automatic compare_all();
        chk("ex_valid", bus.Ex_valid_out, m_valid);
        chk("func", bus.Func_out, m_func);
        chk("a", bus.A_out, m_a);
        chk("b", bus.B_out, m_b);
        chk("pc", bus.Pc_out, m_pc);
        chk("redir_valid", bus.Redirect_valid_out, m_pend);
        chk("redir_pc", bus.Redirect_pc_out, m_rpc);
        chk("illegal", bus.Illegal_out, m_ill);
    endtask

    task automatic cycle();
        bit rdy;
        #1;
        rdy = !m_pend && (!m_valid || bus.Ex_ready_in);
        chk("inst_ready", bus.Inst_ready_out, rdy);
        model_step(rdy);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic offer(input logic [31:0] inst, pc, rs, rt);
        bus.Inst_valid_in = 1; bus.Inst_in = inst; bus.Pc_in = pc;
        bus.Rs_data_in = rs; bus.Rt_data_in = rt;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h09, 6'h00, 6'h3F};
        logic [5:0] ops [17] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        if (k < 3) begin
            w[31:26] = 0; w[5:0] = fns[$urandom_range(0, 13)];
        end else if (k == 3) begin
            w[31:26] = 1; w[20:16] = 5'($urandom_range(0, 2));
        end else w[31:26] = ops[$urandom_range(0, 16)];
        return w;
    endfunction

    initial begin
        bus.Inst_valid_in = 0; bus.Inst_in = 0; bus.Pc_in = 0; bus.Rs_data_in = 0;
        bus.Rt_data_in = 0; bus.Ex_ready_in = 1; bus.Branch_in = 0; bus.Jump_in = 0;
        bus.O_in = 0; bus.Redirect_ready_in = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        chk("reset_ready", bus.Inst_ready_out, 0);
        reset = 0;

        offer(32'h2001FFFB, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("addi_func", bus.Func_out, 6'b100000);
        chk("addi_a", bus.A_out, 32'h0);
        chk("addi_b", bus.B_out, 32'hFFFFFFFB);
        chk("addi_ev", bus.Ex_valid_out, 1);
        offer(32'h3402FFFF, 32'h4, 32'h1, 32'h2);
        cycle();
        chk("ori_func", bus.Func_out, 6'b100101);
        chk("ori_b", bus.B_out, 32'h0000FFFF);
        offer(32'h3C031234, 32'h8, 32'h55, 32'h66);
        cycle();
        chk("lui_func", bus.Func_out, 6'b100101);
        chk("lui_a", bus.A_out, 32'h0);
        chk("lui_b", bus.B_out, 32'h12340000);

        offer(32'h10220003, 32'h100, 32'h5, 32'h5);
        cycle();
        bus.Branch_in = 1;
        offer(32'h2001FFFB, 32'h104, 32'h0, 32'h0);
        cycle();
        bus.Branch_in = 0;
        chk("beq_rv", bus.Redirect_valid_out, 1);
        chk("beq_rpc", bus.Redirect_pc_out, 32'h110);
        chk("beq_slot_ev", bus.Ex_valid_out, DS);
        repeat (2) begin
            cycle();
            chk("hold_rv", bus.Redirect_valid_out, 1);
            chk("hold_ready", bus.Inst_ready_out, 0);
        end
        bus.Redirect_ready_in = 1;
        cycle();
        chk("release_rv", bus.Redirect_valid_out, 0);
        bus.Redirect_ready_in = 0;

        offer(32'h03E00008, 32'h200, 32'h00400020, 32'h0);
        cycle();
        bus.Inst_valid_in = 0;
        bus.Jump_in = 1;
        bus.O_in = 32'h00400020;
        cycle();
        bus.Jump_in = 0;
        chk("jr_rpc", bus.Redirect_pc_out, 32'h00400020);
        bus.Redirect_ready_in = 1;
        offer(32'h2001FFFB, 32'h204, 32'h0, 32'h0);
        repeat (3) cycle();
        bus.Redirect_ready_in = 0;

        offer(32'h00221820, 32'h300, 32'h7, 32'h9);
        cycle();
        bus.Ex_ready_in = 0;
        offer(32'h3402FFFF, 32'h304, 32'h1, 32'h2);
        repeat (3) begin
            cycle();
            chk("stall_func", bus.Func_out, 6'b100000);
            chk("stall_a", bus.A_out, 32'h7);
            chk("stall_b", bus.B_out, 32'h9);
        end
        bus.Ex_ready_in = 1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h2001FFFB, 32'h304 + 32'(i * 4), 32'(i), 32'h0);
            cycle();
            chk("resume_ev", bus.Ex_valid_out, 1);
            chk("resume_pc", bus.Pc_out, 32'h304 + 32'(i * 4));
        end

        offer(32'hFC000000, 32'h400, 32'h0, 32'h0);
        cycle();
        chk("ill_pulse", bus.Illegal_out, 1);
        chk("ill_ev", bus.Ex_valid_out, 0);
        bus.Inst_valid_in = 0;
        cycle();
        chk("ill_end", bus.Illegal_out, 0);

        offer(32'h10220003, 32'h500, 32'h5, 32'h5);
        cycle();
        bus.Branch_in = 1;
        offer(32'h2001FFFB, 32'h504, 32'h0, 32'h0);
        cycle();
        bus.Branch_in = 0;
        bus.Inst_valid_in = 0;
        cycle();
        chk("pre_rst_rv", bus.Redirect_valid_out, 1);
        #2;
        reset = 1;
        #1;
        chk("rst_rv", bus.Redirect_valid_out, 0);
        chk("rst_rpc", bus.Redirect_pc_out, 0);
        chk("rst_ev", bus.Ex_valid_out, 0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 0;
        compare_all();

        repeat (3000) begin
            if ($urandom_range(0, 3) != 0) offer(rand_inst(), $urandom & ~32'h3, $urandom, $urandom);
            else bus.Inst_valid_in = 0;
            bus.Ex_ready_in       = $urandom_range(0, 3) != 0;
            bus.Branch_in         = $urandom_range(0, 3) == 0;
            bus.Jump_in           = $urandom_range(0, 7) == 0;
            bus.O_in              = $urandom;
            bus.Redirect_ready_in = $urandom_range(0, 2) == 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
